// File: rtl/alu_issue_stage.sv
// Issue stage in front of the combinational ALU: a 2-entry request FIFO drives the ALU
// from registers, and the result is captured into a tagged output register.
module alu_issue_stage #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_func,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [1:0]       alu_func,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      op_count
);

    logic [1:0]       func_q [2];
    logic [WIDTH-1:0] a_q    [2];
    logic [WIDTH-1:0] b_q    [2];
    logic [TAG_W-1:0] tag_q  [2];

    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, rd_ptr_q;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [15:0]      op_count_q, op_count_d;

    logic push, pop, out_hs, head_valid;

    always_comb begin
        head_valid   = (count_q != 2'd0);
        push         = in_valid && in_ready_q;
        pop          = head_valid && (!out_valid_q || out_ready);
        out_hs       = out_valid_q && out_ready;

        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;

        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
        // in_ready is registered, so it looks ahead at the post-edge occupancy
        in_ready_d = (count_d < 2'd2);

        if (pop) begin
            out_valid_d  = 1'b1;
            out_result_d = alu_result;
            out_tag_d    = tag_q[rd_ptr_q];
        end else if (out_hs) begin
            out_valid_d  = 1'b0;
        end
        op_count_d = op_count_q + {15'd0, out_hs};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q      <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            op_count_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                func_q[i] <= '0;
                a_q[i]    <= '0;
                b_q[i]    <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            op_count_q   <= op_count_d;
            if (push) begin
                func_q[wr_ptr_q] <= in_func;
                a_q[wr_ptr_q]    <= in_a;
                b_q[wr_ptr_q]    <= in_b;
                tag_q[wr_ptr_q]  <= in_tag;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // ALU inputs come straight from storage registers, zeroed when the FIFO is empty
    assign alu_func   = head_valid ? func_q[rd_ptr_q] : 2'd0;
    assign alu_a      = head_valid ? a_q[rd_ptr_q]    : '0;
    assign alu_b      = head_valid ? b_q[rd_ptr_q]    : '0;

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios with constant expectations plus a
// randomized run checked against a queue-based transaction model.
module tb_alu_issue_stage;

    logic        clock, reset_n;
    logic        in_valid, in_ready;
    logic [1:0]  in_func;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_tag;
    logic [1:0]  alu_func;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic [15:0] op_count;

    int vectors = 0;
    int miscompares = 0;

    alu_issue_stage #(.WIDTH(32), .TAG_W(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .op_count(op_count)
    );

    assign alu_result = alu_a + alu_b;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Transaction model: queue of waiting requests plus the output register contents
    typedef struct {
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  t;
    } ent_t;

    ent_t        q_m[$];
    logic        ov_m, rdy_m;
    logic [31:0] res_m;
    logic [3:0]  tag_m;
    logic [15:0] opc_m;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_m.delete();
            ov_m = 1'b0; rdy_m = 1'b0; res_m = '0; tag_m = '0; opc_m = '0;
        end else begin
            automatic logic hs   = ov_m && out_ready;
            automatic logic pop  = (q_m.size() > 0) && (!ov_m || out_ready);
            automatic logic push = in_valid && rdy_m;
            if (hs) opc_m = opc_m + 16'd1;
            if (pop) begin
                automatic ent_t e = q_m.pop_front();
                res_m = e.a + e.b;
                tag_m = e.t;
                ov_m  = 1'b1;
            end else if (hs) begin
                ov_m = 1'b0;
            end
            if (push) q_m.push_back('{f: in_func, a: in_a, b: in_b, t: in_tag});
            rdy_m = (q_m.size() < 2);
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] t);
        in_valid = v; in_func = f; in_a = a; in_b = b; in_tag = t;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        drive(1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        drive(1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++; if (op_count !== 16'd0 || out_result !== 32'd0 || out_tag !== 4'd0) begin
            miscompares++; $display("FAIL reset_out_regs: got cnt=%h res=%h tag=%h want 0", op_count, out_result, out_tag); end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_before_edge: got %b want 0", in_ready); end
        tick();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_after_edge: got %b want 1", in_ready); end
        vectors++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_func !== 2'd0) begin
            miscompares++; $display("FAIL reset_alu_zero: got f=%h a=%h b=%h want 0", alu_func, alu_a, alu_b); end
    endtask

    task automatic test_single;
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 2'd0, 32'd2, 32'd3, 4'd1);
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
        vectors++; if (alu_a !== 32'd2 || alu_b !== 32'd3) begin
            miscompares++; $display("FAIL single_alu_ops: got a=%h b=%h want 2,3", alu_a, alu_b); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_result !== 32'd5 || out_tag !== 4'd1) begin
            miscompares++; $display("FAIL single_result: got v=%b res=%h tag=%h want 1,5,1", out_valid, out_result, out_tag); end
        tick();
        vectors++; if (op_count !== 16'd1 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL single_handshake: got cnt=%h v=%b want 1,0", op_count, out_valid); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 2'd0, 32'd2, 32'd3, 4'd0);
        tick();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready0: got %b want 1", in_ready); end
        drive(1'b1, 2'd1, 32'd5, 32'd3, 4'd1);
        tick();
        vectors++; if (out_valid !== 1'b1 || out_result !== 32'd5 || out_tag !== 4'd0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL b2b_res0: got v=%b res=%h tag=%h rdy=%b want 1,5,0,1", out_valid, out_result, out_tag, in_ready); end
        drive(1'b1, 2'd2, 32'd7, 32'd1, 4'd2);
        tick();
        vectors++; if (out_valid !== 1'b1 || out_result !== 32'd8 || out_tag !== 4'd1 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL b2b_res1: got v=%b res=%h tag=%h rdy=%b want 1,8,1,1", out_valid, out_result, out_tag, in_ready); end
        in_valid = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b1 || out_result !== 32'd8 || out_tag !== 4'd2) begin
            miscompares++; $display("FAIL b2b_res2: got v=%b res=%h tag=%h want 1,8,2", out_valid, out_result, out_tag); end
        tick();
        vectors++; if (out_valid !== 1'b0 || op_count !== 16'd3) begin
            miscompares++; $display("FAIL b2b_drain: got v=%b cnt=%h want 0,3", out_valid, op_count); end
    endtask

    task automatic test_backpressure;
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 32'd1, 32'd1, 4'd3);
        tick();
        drive(1'b1, 2'd0, 32'd2, 32'd2, 4'd4);
        tick();
        drive(1'b1, 2'd0, 32'd3, 32'd3, 4'd5);
        tick();
        in_valid = 1'b0;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
        vectors++; if (out_valid !== 1'b1 || out_result !== 32'd2 || out_tag !== 4'd3) begin
            miscompares++; $display("FAIL bp_first: got v=%b res=%h tag=%h want 1,2,3", out_valid, out_result, out_tag); end
        repeat (3) tick();
        vectors++; if (out_result !== 32'd2 || alu_a !== 32'd2 || in_ready !== 1'b0) begin
            miscompares++; $display("FAIL bp_hold: got res=%h alu_a=%h rdy=%b want 2,2,0", out_result, alu_a, in_ready); end
        out_ready = 1'b1;
        tick();
        vectors++; if (out_result !== 32'd4 || out_tag !== 4'd4 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_drain1: got res=%h tag=%h rdy=%b want 4,4,1", out_result, out_tag, in_ready); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_result !== 32'd6 || out_tag !== 4'd5) begin
            miscompares++; $display("FAIL bp_drain2: got v=%b res=%h tag=%h want 1,6,5", out_valid, out_result, out_tag); end
        tick();
        vectors++; if (out_valid !== 1'b0 || op_count !== 16'd3) begin
            miscompares++; $display("FAIL bp_done: got v=%b cnt=%h want 0,3", out_valid, op_count); end
    endtask

    task automatic test_wrap;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 70000 && opc_m != 16'hFFFF; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            tick();
        end
        in_valid = 1'b0;
        vectors++; if (op_count !== 16'hFFFF || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL wrap_preload: got cnt=%h v=%b want ffff,1", op_count, out_valid); end
        tick();
        vectors++; if (op_count !== 16'h0000) begin miscompares++; $display("FAIL wrap_rollover: got %h want 0000", op_count); end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 2'd0, 32'd1, 32'd2, 4'd1);
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd1, 32'(i + 10), 32'd1, 4'(i + 2));
            tick();
        end
        in_valid = 1'b0;
        vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || op_count !== 16'd1) begin
            miscompares++; $display("FAIL rstmid_pre: got rdy=%b v=%b cnt=%h want 0,1,1", in_ready, out_valid, op_count); end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_result !== 32'd0 || out_tag !== 4'd0 || op_count !== 16'd0) begin
            miscompares++; $display("FAIL rstmid_out: got rdy=%b v=%b res=%h tag=%h cnt=%h want all 0",
                                    in_ready, out_valid, out_result, out_tag, op_count); end
        vectors++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_func !== 2'd0) begin
            miscompares++; $display("FAIL rstmid_alu: got f=%h a=%h b=%h want 0", alu_func, alu_a, alu_b); end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        out_ready = 1'b1;
        drive(1'b1, 2'd0, 32'd1, 32'd1, 4'd7);
        tick();
        in_valid = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b1 || out_result !== 32'd2 || out_tag !== 4'd7) begin
            miscompares++; $display("FAIL rstmid_new: got v=%b res=%h tag=%h want 1,2,7", out_valid, out_result, out_tag); end
        tick();
        vectors++; if (out_valid !== 1'b0 || op_count !== 16'd1) begin
            miscompares++; $display("FAIL rstmid_stale: got v=%b cnt=%h want 0,1", out_valid, op_count); end
    endtask

    task automatic test_func_zero;
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 2'd3, 32'hFFFF_FFFF, 32'd1, 4'd9);
        tick();
        in_valid = 1'b0;
        vectors++; if (alu_func !== 2'd3 || alu_a !== 32'hFFFF_FFFF || alu_b !== 32'd1) begin
            miscompares++; $display("FAIL func_head: got f=%h a=%h b=%h want 3,ffffffff,1", alu_func, alu_a, alu_b); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_result !== 32'd0 || out_tag !== 4'd9) begin
            miscompares++; $display("FAIL func_wrap_result: got v=%b res=%h tag=%h want 1,0,9", out_valid, out_result, out_tag); end
        vectors++; if (alu_func !== 2'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            miscompares++; $display("FAIL func_empty_zero: got f=%h a=%h b=%h want 0", alu_func, alu_a, alu_b); end
        tick();
    endtask

    task automatic test_random;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) < 60), 2'($urandom_range(0, 3)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            out_ready = ($urandom_range(0, 99) < 55);
            tick();
            vectors++; if (out_valid !== ov_m || in_ready !== rdy_m || op_count !== opc_m) begin
                miscompares++; $display("FAIL rand_ctrl[%0d]: got v=%b rdy=%b cnt=%h want %b,%b,%h",
                                        i, out_valid, in_ready, op_count, ov_m, rdy_m, opc_m); end
            if (ov_m) begin
                vectors++; if (out_result !== res_m || out_tag !== tag_m) begin
                    miscompares++; $display("FAIL rand_data[%0d]: got res=%h tag=%h want %h,%h", i, out_result, out_tag, res_m, tag_m); end
            end
            if (q_m.size() > 0) begin
                vectors++; if (alu_func !== q_m[0].f || alu_a !== q_m[0].a || alu_b !== q_m[0].b) begin
                    miscompares++; $display("FAIL rand_alu[%0d]: got f=%h a=%h b=%h want %h,%h,%h",
                                            i, alu_func, alu_a, alu_b, q_m[0].f, q_m[0].a, q_m[0].b); end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_a !== 32'd0) begin
            miscompares++; $display("FAIL rand_drain: got v=%b rdy=%b alu_a=%h want 0,1,0", out_valid, in_ready, alu_a); end
    endtask

    initial begin
        reset_n = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 2'd0, 32'd0, 32'd0, 4'd0);
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_func_zero();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Operand issue and result capture stage in front of the team's combinational `alu` (`func[1:0]`, `a`, `b`, `result`). It accepts tagged operation requests over a valid/ready handshake and buffers them in a 2-entry FIFO. It presents the FIFO head to the ALU from registers so ALU inputs are glitch-free, and captures the ALU result into a tagged output register with its own valid/ready handshake. The `func` encoding is opaque to this block and is passed through unchanged.

## Interface
- `WIDTH`, 32, operand/result width
- `TAG_W`, 4, request tag width

- `clock`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  request valid
- `in_ready`  out  1  request accepted when `in_valid && in_ready` at a rising edge
- `in_func`  in  2  ALU function code
- `in_a`, `in_b`  in  WIDTH  operands
- `in_tag`  in  TAG_W  request tag
- `alu_func`  out  2  to ALU `func`
- `alu_a`, `alu_b`  out  WIDTH  to ALU `a`, `b`
- `alu_result`  in  WIDTH  from ALU `result` (combinational from `alu_*`)
- `out_valid`  out  1  result valid
- `out_ready`  in  1  result consumed when `out_valid && out_ready` at a rising edge
- `out_result`  out  WIDTH  captured result
- `out_tag`  out  TAG_W  tag of captured result
- `op_count`  out  16  completed output handshakes, wraps

## Operation
- FIFO: 2 entries {func, a, b, tag}, registered `count` 0..2, read/write pointers 1 bit each.
- `in_ready` is registered: it resets to 0 and equals (next `count` < 2) after each edge. It does not depend combinationally on `out_ready`.
- Push on the input handshake. Pop when the head is valid and the output register can load (`!out_valid || out_ready`). The result is captured in the same cycle as the pop.
- `alu_func/alu_a/alu_b` = head entry fields when `count` > 0, else all zeros.
- Capture: on pop, `out_result <= alu_result`, `out_tag <= head.tag`, `out_valid <= 1`.
- Output handshake without a pop: `out_valid <= 0`. `out_result`/`out_tag` hold their last values.
- Simultaneous push and pop: `count` is unchanged and pointers both advance. Push at `count` == 2 cannot occur because `in_ready` is 0.
- `op_count` increments by 1 on each output handshake and wraps 0xFFFF -> 0x0000.
- Order is strictly FIFO. No request is dropped or duplicated.
- Reset (async assert, any time, including mid-operation) has these effects:
  - `count` = 0, pointers = 0.
  - `in_ready` = 0, `out_valid` = 0.
  - `out_result` = 0, `out_tag` = 0, `op_count` = 0.
  - `alu_*` = 0.
  - In-flight entries are discarded.

## Timing
- Request accepted at edge k: it becomes head after edge k if the FIFO was empty, and `alu_*` is valid for the cycle after k.
- With an empty FIFO and free output, `out_valid` rises after edge k+1. Request-to-result latency is 2 edges.
- Throughput: 1 op/cycle sustained while `out_ready` = 1.
- Output backpressure (`out_ready` = 0 with `out_valid` = 1): the head stays on `alu_*`. The FIFO fills to 2, and `in_ready` falls after the edge that makes `count` = 2.
- `in_ready` is first 1 after the first rising edge following `reset_n` deassertion.
- `out_*` change only at rising edges or async reset.

## Test plan
Bench stub: `alu_result = alu_a + alu_b` (mod 2^WIDTH).
- Single op: reset, then push a=2, b=3, tag=1 with `out_ready` = 1 -> `out_valid` high exactly 2 edges after acceptance with `out_result` = 5, `out_tag` = 1; `op_count` = 1 after the handshake.
- Back-to-back: push (2,3,t0), (5,3,t1), (7,1,t2) on consecutive cycles with `out_ready` = 1 -> results 5, 8, 8 with tags 0, 1, 2 on consecutive cycles; `in_ready` stays 1.
- Backpressure: hold `out_ready` = 0 and push 3 ops -> after the first result captures, the FIFO holds 2 and `in_ready` = 0. `out_result` holds the first result. Releasing `out_ready` drains in order with no loss.
- Wrap: preload 65535 handshakes (or force `op_count` = 0xFFFF) -> the next handshake gives `op_count` = 0.
- Reset mid-operation: assert `reset_n` = 0 with the FIFO full and `out_valid` = 1 -> all outputs 0 immediately, without a clock edge. After release, a new op (1,1) yields 2 with no stale results.
- Func/zero pass-through: push func=3, a=0xFFFFFFFF, b=1 -> `alu_func` = 3 while head; `out_result` = 0 (wrap). `alu_*` = 0 when the FIFO is empty.
